// File: rtl/de_bruijn_pkg.sv
// Shared de Bruijn definitions: tap table, next-bit rule, sync FSM states.
// Used by the reference generator and the receiver.
package de_bruijn_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam int N_MIN = 3;
  localparam int N_MAX = 8;

  function automatic logic [7:0] tap_mask(input int n);
    case (n)
      3:       return 8'b0000_0110;
      4:       return 8'b0000_1100;
      5:       return 8'b0001_0100;
      6:       return 8'b0011_0000;
      7:       return 8'b0110_0000;
      8:       return 8'b1011_1000;
      default: return 8'b0000_1100;
    endcase
  endfunction

  // LFSR feedback plus the zero-run fixup that inserts the
  // all-zero window, stretching the m-sequence to 2^n.
  function automatic logic next_bit(
    input logic [7:0] w,
    input int         n
  );
    logic [7:0] low;
    low = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n - 1) low[i] = 1'b1;
    end
    return (^(w & tap_mask(n))) ^ ((w & low) == 8'd0);
  endfunction

endpackage

// File: rtl/de_bruijn_ref.sv
// Reference de Bruijn generator with index counter.
// Ports: clk, rst, clear (back to index 0), step, window, index.
module de_bruijn_ref
  import de_bruijn_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  output logic [N-1:0] window,
  output logic [N-1:0] index
);

  logic [7:0] wide;

  always_comb begin
    wide         = '0;
    wide[N-1:0]  = window;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
      index  <= '0;
    end else if (clear) begin
      window <= '0;
      index  <= '0;
    end else if (step) begin
      window <= {window[N-2:0], next_bit(wide, N)};
      index  <= index + 1'b1;
    end
  end

endmodule

// File: rtl/de_bruijn_sync.sv
// de Bruijn stream synchroniser: fill window, search, lock and track.
// Ports: clk, rst, bit_in/bit_valid/bit_ready, locked, position, bit_err, err_count.
module de_bruijn_sync
  import de_bruijn_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAX_ERR = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         bit_ready,
  output logic         locked,
  output logic [N-1:0] position,
  output logic         bit_err,
  output logic [15:0]  err_count
);

  state_t       state;
  state_t       state_next;
  logic [3:0]   fill_cnt;
  logic [3:0]   err_streak;
  logic [N-1:0] win;
  logic [N-1:0] ref_win;
  logic [N-1:0] ref_idx;
  logic [7:0]   win_wide;
  logic         xfer;
  logic         match;
  logic         expected;
  logic         mismatch;
  logic         fill_done;
  logic         drop;
  logic         ref_clear;
  logic         ref_step;

  always_comb begin
    win_wide         = '0;
    win_wide[N-1:0]  = win;
  end

  assign expected  = next_bit(win_wide, N);
  assign xfer      = bit_valid && bit_ready;
  assign match     = (ref_win == win);
  assign mismatch  = (bit_in != expected);
  assign fill_done = (fill_cnt == 4'(N - 1));
  assign drop      = mismatch && (err_streak == 4'(MAX_ERR - 1));

  de_bruijn_ref #(.N(N)) u_ref (
    .clk    (clk),
    .rst    (rst),
    .clear  (ref_clear),
    .step   (ref_step),
    .window (ref_win),
    .index  (ref_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (xfer && fill_done) state_next = SEARCH;
      SEARCH:  if (match)             state_next = LOCK;
      LOCK:    if (xfer && drop)      state_next = FILL;
      default:                        state_next = FILL;
    endcase
  end

  // Generator is held at index 0 outside SEARCH so every
  // search starts from the head of the sequence.
  always_comb begin
    bit_ready = (state != SEARCH);
    ref_clear = (state != SEARCH);
    ref_step  = (state == SEARCH) && !match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt   <= '0;
      err_streak <= '0;
      win        <= '0;
      locked     <= 1'b0;
      position   <= '0;
      bit_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      bit_err <= 1'b0;
      unique case (state)
        FILL: begin
          if (xfer) begin
            win      <= {win[N-2:0], bit_in};
            fill_cnt <= fill_cnt + 4'd1;
          end
        end
        SEARCH: begin
          if (match) begin
            locked   <= 1'b1;
            position <= ref_idx;
          end
        end
        LOCK: begin
          if (xfer) begin
            // Flywheel: window follows the sequence, not the line.
            win      <= {win[N-2:0], expected};
            position <= position + 1'b1;
            if (mismatch) begin
              bit_err <= 1'b1;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              if (drop) begin
                locked     <= 1'b0;
                fill_cnt   <= '0;
                err_streak <= '0;
              end else begin
                err_streak <= err_streak + 4'd1;
              end
            end else begin
              err_streak <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/de_bruijn_sync.md
Name: de_bruijn_sync

Overview:
- Receive-side partner of the de Bruijn sequence generator.
- Accepts the serial de Bruijn bit stream over a valid/ready handshake and fills an N-bit window.
- Searches the sequence for that window, locks, then tracks the stream bit-by-bit.
- Reports the absolute position in the sequence and counts bit errors, so a link or test harness can check the generator end-to-end.

Parameters:
- N, 4, window width; legal values 3..8; sequence period 2^N.
- MAX_ERR, 3, consecutive mismatches in LOCK that drop lock; legal values 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  serial sequence bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  block accepts a bit this cycle; a transfer occurs when bit_valid && bit_ready.
- locked  out  1  window matched and tracking.
- position  out  N  sequence index of the current window; meaningful only while locked.
- bit_err  out  1  one-cycle pulse on a mismatching accepted bit in LOCK.
- err_count  out  16  total mismatches since reset, saturates at 16'hFFFF.

Behaviour:
- Sequence definition (shared with the generator):
  - Window W, newest bit at LSB; shift is W' = {W[N-2:0], b}.
  - b = XOR of W tap bits, XOR (W[N-2:0]==0).
  - Tap bits per N: 3:{2,1}; 4:{3,2}; 5:{4,2}; 6:{5,4}; 7:{6,5}; 8:{7,5,4,3}.
  - Index 0 = all-zero window; index k = window after k steps from 0.
  - N=4 order: 0000,0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000.
- Reset (async): state=FILL, fill_cnt=0, W=0, locked=0, position=0, bit_err=0, err_count=0, err_streak=0.
- bit_ready = (state != SEARCH), combinational from state.
- FILL:
  - Each transfer shifts bit_in into W and increments fill_cnt.
  - On the transfer that makes fill_cnt==N, go to SEARCH next cycle.
- SEARCH:
  - Internal generator g starts at 0 with index counter idx=0.
  - Each cycle compares g to W. On mismatch, g steps and idx increments.
  - On match: next cycle state=LOCK, locked=1, position=idx.
  - A window at index k is found in the (k+1)th SEARCH cycle; worst case 2^N cycles.
  - No transfers occur while in SEARCH.
- LOCK, per transfer:
  - expected = b(W). W shifts in expected (flywheel, not bit_in). position increments, wrapping 2^N-1 -> 0.
  - If bit_in == expected: err_streak=0.
  - Else: bit_err=1 for one cycle, err_count+1 (saturating), err_streak+1.
  - If err_streak reaches MAX_ERR: next state FILL, locked=0, fill_cnt=0, err_streak=0. W is refilled from fresh bits.
  - No transfer: all registers hold, bit_err=0.
- Outputs are registered; position and locked update the cycle after the causing transfer or match.
- Reset mid-operation returns to FILL immediately. A partially filled window is discarded.

Decomposition:
- Package de_bruijn_pkg holds:
  - the tap-mask table for N=3..8;
  - a next_bit(W) function used by both generator and receiver;
  - the state enum FILL/SEARCH/LOCK.
- One sub-module de_bruijn_ref holds the resettable/loadable reference generator (state + index counter) used in SEARCH. Instantiate it; do not duplicate it.

Test Plan:
- N=4, reset, send 1,0,0,1 -> W=1001; SEARCH lasts 5 cycles with bit_ready=0; locked=1, position=4. Next bit 1 -> position=5, bit_err=0.
- Send a window ending 1000 -> SEARCH 16 cycles, position=15. Next bit 0 -> position=0 (wrap), no error.
- Locked at position 7, send one flipped bit -> bit_err single pulse, err_count=1, locked stays 1, position=8. Following correct bits track normally.
- Locked, send 3 consecutive flipped bits -> bit_err pulses x3, err_count=3, locked=0 after the 3rd. 4 correct bits later -> relock at the true index.
- Hold bit_valid=1 through SEARCH -> no transfers, bit_ready=0 every SEARCH cycle. The held bit is consumed on the first LOCK cycle.
- Assert rst asynchronously mid-SEARCH and mid-LOCK (err_count=2) -> locked=0, err_count=0, position=0, bit_ready=1 without waiting for a clock edge.
